// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared state encoding and default sizes for the adder round-robin scheduler.
package adder_sched_pkg;
  localparam int DEF_NREQ   = 4;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational pick of the first requester at or after ptr, wrapping upward.
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx
);
  logic [IW-1:0] j;
  // Scan from farthest to nearest so the requester closest to ptr wins last.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    j       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = ptr + IW'(k);
      if (req[j]) begin
        win_oh  = NREQ'(1) << j;
        win_idx = j;
      end
    end
  end
endmodule

// File: rtl/adder_rr_sched.sv
// adder_rr_sched: shares one free-running 4-operand adder among NREQ requesters, round-robin,
// discarding the first misaligned fin and timing out a silent adder.
module adder_rr_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 12,
  localparam int IW = $clog2(NREQ),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*4*DATA_W-1:0] req_op,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DATA_W-1:0]        resp_sum,
  output logic                     resp_err,
  output logic [DATA_W-1:0]        add_in1,
  output logic [DATA_W-1:0]        add_in2,
  output logic [DATA_W-1:0]        add_in3,
  output logic [DATA_W-1:0]        add_in4,
  input  logic [DATA_W-1:0]        add_sum,
  input  logic                     add_fin
);
  state_t                state_q, state_d;
  logic [NREQ-1:0]       gnt_q, gnt_d, done_q, done_d;
  logic [DATA_W-1:0]     sum_q, sum_d;
  logic                  err_q, err_d;
  logic [4*DATA_W-1:0]   ops_q, ops_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NREQ-1:0]       win_oh;
  logic [IW-1:0]         win_idx;
  logic                  tmo;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  // The cycle in which the TIMEOUT-th ALIGN/WAIT cycle elapses.
  assign tmo = cnt_q == CW'(TIMEOUT - 1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    sum_d   = sum_q;
    err_d   = err_q;
    ops_d   = ops_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|req) begin
        ops_d   = req_op[int'(win_idx)*4*DATA_W +: 4*DATA_W];
        gnt_d   = win_oh;
        ptr_d   = win_idx + IW'(1);
        cnt_d   = '0;
        state_d = ALIGN;
      end
      ALIGN, WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (state_q == WAIT && add_fin) begin
          sum_d   = add_sum;
          err_d   = 1'b0;
          done_d  = gnt_q;
          state_d = RESP;
        end else if (tmo) begin
          sum_d   = '0;
          err_d   = 1'b1;
          done_d  = gnt_q;
          state_d = RESP;
        end else if (add_fin) begin
          state_d = WAIT;
        end
      end
      RESP: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      ops_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      ops_q   <= ops_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign resp_sum = sum_q;
  assign resp_err = err_q;
  assign add_in1  = ops_q[0*DATA_W +: DATA_W];
  assign add_in2  = ops_q[1*DATA_W +: DATA_W];
  assign add_in3  = ops_q[2*DATA_W +: DATA_W];
  assign add_in4  = ops_q[3*DATA_W +: DATA_W];
endmodule

// File: tb/tb_adder_rr_sched.sv
// tb_adder_rr_sched: scoreboard bench with a free-running 4-phase adder model.
module tb_adder_rr_sched;
  localparam int NREQ = 4, DW = 16, TMO = 12;
  logic clk = 0, rst_n = 0, fin_en = 1;
  logic [NREQ-1:0] req = '0, gnt, done;
  logic [NREQ*4*DW-1:0] req_op = '0;
  logic [DW-1:0] resp_sum, a1, a2, a3, a4, add_sum;
  logic resp_err, add_fin;
  logic [1:0] ph = 2'd0;
  logic [DW-1:0] lat = '0;
  typedef struct packed {logic [NREQ-1:0] d; logic [DW-1:0] s; logic e;} exp_t;
  exp_t sb[$];
  exp_t em;
  int checks = 0, errors = 0, cyc = 0, g_cyc = 0, n_lat;
  logic [NREQ-1:0] g_vec = '0, gnt_prev = '0;

  always #5 clk = ~clk;

  adder_rr_sched #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .gnt(gnt), .done(done),
    .resp_sum(resp_sum), .resp_err(resp_err), .add_in1(a1), .add_in2(a2), .add_in3(a3),
    .add_in4(a4), .add_sum(add_sum), .add_fin(add_fin)
  );

  always @(posedge clk) begin
    ph <= ph + 2'd1;
    if (ph == 2'd0) lat <= a1 + a2 + a3 + a4;
  end
  assign add_sum = lat;
  assign add_fin = fin_en && ph == 2'd3;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != 0 && gnt_prev == 0) begin
        g_cyc = cyc;
        g_vec = gnt;
      end
      if (|done) begin
        if (sb.size() == 0) check("sb_empty", {28'd0, done}, 32'd0);
        else begin
          em = sb.pop_front();
          n_lat = cyc - g_cyc + 1;
          check("done_vec", {28'd0, done}, {28'd0, em.d});
          check("sum", {16'd0, resp_sum}, {16'd0, em.s});
          check("err", {31'd0, resp_err}, {31'd0, em.e});
          check("gnt_hold", {28'd0, gnt}, {28'd0, g_vec});
          if (em.e) check("lat_tmo", n_lat, TMO + 1);
          else check("lat_ok", {31'd0, n_lat >= 6 && n_lat <= 9}, 32'd1);
        end
      end
    end
    gnt_prev = gnt;
  end

  task automatic set_ops(int i, logic [DW-1:0] o0, o1, o2, o3);
    req_op[i*4*DW +: 4*DW] = {o3, o2, o1, o0};
  endtask

  task automatic push(int i, logic [DW-1:0] s, logic e);
    exp_t x;
    x.d = NREQ'(1) << i;
    x.s = s;
    x.e = e;
    sb.push_back(x);
  endtask

  task automatic wait_done(int i);
    int n = 0;
    @(negedge clk);
    while (!done[i] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_done", {31'd0, done[i]}, 32'd1);
    req[i] = 1'b0;
  endtask

  task automatic run_one(int i, logic [DW-1:0] o0, o1, o2, o3, s, logic e);
    set_ops(i, o0, o1, o2, o3);
    push(i, s, e);
    req[i] = 1'b1;
    wait_done(i);
    @(negedge clk);
  endtask

  initial begin
    int ord[5] = '{0, 1, 2, 3, 0};
    int n;
    repeat (2) @(negedge clk);
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_done", {28'd0, done}, 32'd0);
    check("rst_resp", {15'd0, resp_err, resp_sum}, 32'd0);
    check("rst_ops", {a1 | a2, a3 | a4}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) set_ops(i, DW'(4 * (i + 1)), DW'(4 * (i + 1)), DW'(4 * (i + 1)), DW'(4 * (i + 1)));
    for (int k = 0; k < 5; k++) push(ord[k], DW'(16 * (ord[k] + 1)), 1'b0);
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_done(ord[k]);
      if (k == 4) req = '0;
      else begin
        @(negedge clk);
        req[ord[k]] = 1'b1;
      end
    end
    @(negedge clk);
    run_one(0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd10, 1'b0);
    run_one(3, 16'hFFFF, 16'h0001, 16'h8000, 16'h8000, 16'h0000, 1'b0);
    set_ops(2, 16'd5, 16'd6, 16'd7, 16'd8);
    push(2, 16'd26, 1'b0);
    req[2] = 1'b1;
    fork
      wait_done(2);
      repeat (14) begin
        @(negedge clk);
        if (gnt[2]) req_op[2*4*DW +: 4*DW] = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      end
    join
    @(negedge clk);
    fin_en = 1'b0;
    run_one(1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 1'b1);
    fin_en = 1'b1;
    run_one(1, 16'd3, 16'd3, 16'd3, 16'd3, 16'd12, 1'b0);
    set_ops(2, 16'd9, 16'd9, 16'd9, 16'd9);
    push(2, 16'd36, 1'b0);
    req[2] = 1'b1;
    n = 0;
    while (!gnt[2] && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_gnt", {31'd0, gnt[2]}, 32'd1);
    n = 0;
    while (!add_fin && n < 8) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    check("mid_rst_done", {28'd0, done}, 32'd0);
    check("mid_rst_ops", {a1 | a2, a3 | a4}, 32'd0);
    sb.delete();
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    set_ops(2, 16'd1, 16'd1, 16'd1, 16'd1);
    set_ops(3, 16'd2, 16'd2, 16'd2, 16'd2);
    push(2, 16'd4, 1'b0);
    push(3, 16'd8, 1'b0);
    req = 4'b1100;
    wait_done(2);
    wait_done(3);
    repeat (3) @(negedge clk);
    check("sb_drain", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
